mem_store_fwd_buffer: RTL and testbench
=======================================

// Module: mem_store_fwd_buffer
// PURPOSE
//  Store-data forwarding unit for the memory stage of the pipelined core.
//  Replaces the single-level SW forwarding mux with a DEPTH-entry history of retired register writes.
//  A store reading stale register-file data receives the youngest matching value from either
//  the same-cycle writeback or the history. Sits between the RF-read data path and the data-memory write-data input.
// PARAMETERS
//  WIDTH   16  data width of registers and memory words
//  NREGS   8   architectural register count; RAW = clog2(NREGS) index bits
//  DEPTH   4   history entries (retired writes remembered), >=1
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous reset, active-low
//  flush        in   1      clear all history entries (branch/JLR redirect)
//  stall        in   1      freeze history (pipeline stalled)
//  wb_valid     in   1      writeback stage writes a register this cycle
//  wb_cancel    in   1      conditional op (ADC/ADZ/NDC/NDZ) suppressed by flags; no write
//  wb_reg       in   RAW    writeback destination register
//  wb_data      in   WIDTH  writeback data (ALU result or load data)
//  st_valid     in   1      memory stage holds a store (SW, or one SM beat)
//  st_reg       in   RAW    register supplying store data
//  rf_data      in   WIDTH  store data as read from register file
//  st_data      out  WIDTH  store data to data memory (forwarded or rf_data)
//  fwd_hit      out  1      st_data came from writeback/history
//  fwd_src      out  2      0 none, 1 same-cycle writeback, 2 history
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all entry valid bits cleared; entry data/reg don't-care.
//  - While rst_n=0: fwd_hit=0, fwd_src=0, st_data=rf_data.
//  - Push condition: rst_n & wb_valid & ~wb_cancel & ~stall & ~flush.
//  - On push: entry[0] <= {1,wb_reg,wb_data}; entry[i] <= entry[i-1] for i=1..DEPTH-1; entry[DEPTH-1] discarded.
//  - On push, older entries with reg==wb_reg are invalidated; at most one valid entry per register.
//  - flush (rst_n=1): all valid bits cleared next edge. flush takes priority over push and stall.
//  - stall without flush: history held unchanged, including pending writeback.
//    The stage holds its writeback during a stall and re-presents it later.
//  - Lookup is combinational, zero latency, and gated by st_valid (st_valid=0: fwd_hit=0, st_data=rf_data).
//  - Lookup priority:
//      1. same-cycle writeback (wb_valid & ~wb_cancel & wb_reg==st_reg) -> wb_data, fwd_src=1
//      2. valid history entry with reg==st_reg -> its data, fwd_src=2
//      3. otherwise rf_data, fwd_src=0
//  - Same-cycle writeback bypass applies even when stall=1.
//  - Cancelled writeback (wb_cancel=1): never forwarded, never recorded.
//  - History full: oldest entry silently dropped; the RF holds that value by then.
//  - Register indices compare over RAW bits only; no register is treated specially.
//  - No arithmetic; data passes bit-exact.
// CONFIGURATION
//  MEM_FWD_STATS_EN defined:
//   - Adds output hit_count [15:0].
//   - Increments on every clk with fwd_hit=1 and stall=0.
//   - Saturates at 16'hFFFF.
//   - Cleared by reset, not by flush.
//  MEM_FWD_STATS_EN undefined: no port, no counter; behaviour otherwise identical.
// TESTING
//  1 reset: rst_n=0 2 cycles, st_valid=1 st_reg=3 rf_data=16'h1111 -> st_data=16'h1111, fwd_hit=0.
//  2 bypass: wb_valid=1 wb_reg=2 wb_data=16'hABCD, st_reg=2 same cycle -> st_data=16'hABCD, fwd_src=1.
//  3 history/dup: push r2=16'h0001, then r2=16'h0002;
//    store r2 next cycle -> 16'h0002, fwd_src=2 (older invalidated).
//  4 overflow: push r0..r4 (DEPTH=4), values 16'h10+i; store r0 -> rf_data, fwd_hit=0;
//    store r1 -> 16'h0011.
//  5 cancel/flush: wb_cancel=1 write r5 -> not forwarded;
//    push r6=16'h6666 then flush=1 -> store r6 next cycle gives rf_data.
//  6 stall: stall=1 with wb_valid r7=16'h7777 -> same-cycle hit (src=1);
//    next cycle, stall still 1 and no wb -> no hit;
//    with MEM_FWD_STATS_EN, hit_count unchanged across stalled hit.

Source files
------------

// File: rtl/mem_store_fwd_buffer.sv
// Store-data forwarding for the memory stage: same-cycle writeback bypass plus a DEPTH-entry history of retired register writes.
// Optional MEM_FWD_STATS_EN adds a saturating hit_count output.
module mem_store_fwd_buffer #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int DEPTH = 4,
  localparam int RAW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             stall,
  input  logic             wb_valid,
  input  logic             wb_cancel,
  input  logic [RAW-1:0]   wb_reg,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             st_valid,
  input  logic [RAW-1:0]   st_reg,
  input  logic [WIDTH-1:0] rf_data,
  output logic [WIDTH-1:0] st_data,
  output logic             fwd_hit,
  output logic [1:0]       fwd_src
`ifdef MEM_FWD_STATS_EN
  ,
  output logic [15:0]      hit_count
`endif
);

  logic [DEPTH-1:0] entryValid;
  logic [RAW-1:0]   entryReg  [DEPTH];
  logic [WIDTH-1:0] entryData [DEPTH];

  logic             wbLive;
  logic             doPush;
  logic             histHit;
  logic [WIDTH-1:0] histData;

  assign wbLive = wb_valid & ~wb_cancel;
  assign doPush = wbLive & ~stall & ~flush;

  // Shifting on push keeps entry 0 youngest; older copies of the same register are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      entryValid <= '0;
    end else if (doPush) begin
      entryValid[0] <= 1'b1;
      entryReg[0]   <= wb_reg;
      entryData[0]  <= wb_data;
      for (int i = 1; i < DEPTH; i++) begin
        entryValid[i] <= entryValid[i-1] && (entryReg[i-1] != wb_reg);
        entryReg[i]   <= entryReg[i-1];
        entryData[i]  <= entryData[i-1];
      end
    end
  end

  always_comb begin
    histHit  = 1'b0;
    histData = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entryValid[i] && (entryReg[i] == st_reg)) begin
        histHit  = 1'b1;
        histData = entryData[i];
      end
    end
  end

  always_comb begin
    st_data = rf_data;
    fwd_hit = 1'b0;
    fwd_src = 2'd0;
    if (rst_n && st_valid) begin
      if (wbLive && (wb_reg == st_reg)) begin
        st_data = wb_data;
        fwd_hit = 1'b1;
        fwd_src = 2'd1;
      end else if (histHit) begin
        st_data = histData;
        fwd_hit = 1'b1;
        fwd_src = 2'd2;
      end
    end
  end

`ifdef MEM_FWD_STATS_EN
  // Stalled cycles re-present the same store, so they are not counted again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (fwd_hit && !stall && (hit_count != 16'hFFFF)) begin
      hit_count <= hit_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_store_fwd_buffer.sv
// Scoreboard bench for mem_store_fwd_buffer: directed scenarios then random traffic against a queue-based history model.
// Checks hit_count as well when MEM_FWD_STATS_EN is defined.
module tb_mem_store_fwd_buffer;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int DEPTH = 4;
  localparam int RAW   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             stall = 1'b0;
  logic             wb_valid = 1'b0;
  logic             wb_cancel = 1'b0;
  logic [RAW-1:0]   wb_reg = '0;
  logic [WIDTH-1:0] wb_data = '0;
  logic             st_valid = 1'b0;
  logic [RAW-1:0]   st_reg = '0;
  logic [WIDTH-1:0] rf_data = '0;
  logic [WIDTH-1:0] st_data;
  logic             fwd_hit;
  logic [1:0]       fwd_src;
`ifdef MEM_FWD_STATS_EN
  logic [15:0]      hit_count;
`endif

  mem_store_fwd_buffer #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .stall(stall),
    .wb_valid(wb_valid),
    .wb_cancel(wb_cancel),
    .wb_reg(wb_reg),
    .wb_data(wb_data),
    .st_valid(st_valid),
    .st_reg(st_reg),
    .rf_data(rf_data),
    .st_data(st_data),
    .fwd_hit(fwd_hit),
    .fwd_src(fwd_src)
`ifdef MEM_FWD_STATS_EN
    ,
    .hit_count(hit_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [15:0] data;
    logic       hit;
    logic [1:0] src;
    logic [15:0] cnt;
  } expT;

  expT sbq[$];

  // Reference history: writes retired since the last flush/reset, youngest first, at most DEPTH long.
  logic [RAW-1:0]   modelReg[$];
  logic [WIDTH-1:0] modelData[$];
  logic [15:0]      modelCount = 16'd0;

  int numChecks = 0;
  int numFails = 0;

  task automatic applyStimulus(input string tag, input logic rstN, input logic flushI, input logic stallI,
                               input logic wbV, input logic wbC, input logic [RAW-1:0] wbR,
                               input logic [WIDTH-1:0] wbD, input logic stV, input logic [RAW-1:0] stR,
                               input logic [WIDTH-1:0] rfD);
    expT e;
    bit  found;
    @(posedge clk);
    #1;
    rst_n = rstN; flush = flushI; stall = stallI;
    wb_valid = wbV; wb_cancel = wbC; wb_reg = wbR; wb_data = wbD;
    st_valid = stV; st_reg = stR; rf_data = rfD;

    e.tag = tag; e.data = rfD; e.hit = 1'b0; e.src = 2'd0; e.cnt = modelCount;
    if (rstN && stV) begin
      if (wbV && !wbC && wbR == stR) begin
        e.data = wbD; e.hit = 1'b1; e.src = 2'd1;
      end else begin
        found = 1'b0;
        for (int i = 0; i < modelReg.size(); i++) begin
          if (!found && modelReg[i] == stR) begin
            found = 1'b1; e.data = modelData[i]; e.hit = 1'b1; e.src = 2'd2;
          end
        end
      end
    end
    sbq.push_back(e);

    // Effect of the coming clock edge on the model.
    if (!rstN) modelCount = 16'd0;
    else if (e.hit && !stallI && modelCount != 16'hFFFF) modelCount = modelCount + 16'd1;
    if (!rstN || flushI) begin
      modelReg.delete(); modelData.delete();
    end else if (wbV && !wbC && !stallI) begin
      modelReg.push_front(wbR); modelData.push_front(wbD);
      if (modelReg.size() > DEPTH) begin
        void'(modelReg.pop_back()); void'(modelData.pop_back());
      end
    end
  endtask

  task automatic checkOutput(input expT e);
    numChecks++;
    if (st_data !== e.data || fwd_hit !== e.hit || fwd_src !== e.src) begin
      numFails++;
      $display("[TB] FAIL %s: got data=%h hit=%b src=%0d, expected data=%h hit=%b src=%0d",
               e.tag, st_data, fwd_hit, fwd_src, e.data, e.hit, e.src);
    end
`ifdef MEM_FWD_STATS_EN
    numChecks++;
    if (hit_count !== e.cnt) begin
      numFails++;
      $display("[TB] FAIL %s hit_count: got %h, expected %h", e.tag, hit_count, e.cnt);
    end
`endif
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) checkOutput(sbq.pop_front());
  end

  initial begin
    int waitCycles;
    // Reset with a store presented
    applyStimulus("reset0", 0, 0, 0, 0, 0, 0, 16'h0, 1, 3, 16'h1111);
    applyStimulus("reset1", 0, 0, 0, 0, 0, 0, 16'h0, 1, 3, 16'h1111);
    // Same-cycle bypass
    applyStimulus("bypass", 1, 0, 0, 1, 0, 2, 16'hABCD, 1, 2, 16'h2222);
    // History with duplicate register
    applyStimulus("dupA", 1, 0, 0, 1, 0, 2, 16'h0001, 0, 0, 16'h0000);
    applyStimulus("dupB", 1, 0, 0, 1, 0, 2, 16'h0002, 0, 0, 16'h0000);
    applyStimulus("dupStore", 1, 0, 0, 0, 0, 0, 16'h0, 1, 2, 16'h2222);
    // Overflow past DEPTH
    applyStimulus("ovfFlush", 1, 1, 0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
    for (int i = 0; i < 5; i++)
      applyStimulus("ovfPush", 1, 0, 0, 1, 0, RAW'(i), 16'h0010 + 16'(i), 0, 0, 16'h0);
    applyStimulus("ovfR0", 1, 0, 0, 0, 0, 0, 16'h0, 1, 0, 16'h5A5A);
    applyStimulus("ovfR1", 1, 0, 0, 0, 0, 0, 16'h0, 1, 1, 16'h5A5A);
    applyStimulus("ovfR4", 1, 0, 0, 0, 0, 0, 16'h0, 1, 4, 16'h5A5A);
    // Cancel and flush
    applyStimulus("cancel", 1, 0, 0, 1, 1, 5, 16'h5555, 1, 5, 16'h0505);
    applyStimulus("cancelNext", 1, 0, 0, 0, 0, 0, 16'h0, 1, 5, 16'h0505);
    applyStimulus("pushR6", 1, 0, 0, 1, 0, 6, 16'h6666, 0, 0, 16'h0);
    applyStimulus("flushR6", 1, 1, 0, 0, 0, 0, 16'h0, 1, 6, 16'h0606);
    applyStimulus("afterFlush", 1, 0, 0, 0, 0, 0, 16'h0, 1, 6, 16'h0606);
    // Stall: bypass still works, nothing recorded
    applyStimulus("stallHit", 1, 0, 1, 1, 0, 7, 16'h7777, 1, 7, 16'h0707);
    applyStimulus("stallNoWb", 1, 0, 1, 0, 0, 0, 16'h0, 1, 7, 16'h0707);
    applyStimulus("stallEnd", 1, 0, 0, 0, 0, 0, 16'h0, 1, 7, 16'h0707);

    for (int n = 0; n < 600; n++) begin
      applyStimulus("random", ($urandom_range(99) >= 2), ($urandom_range(99) < 4),
                    ($urandom_range(99) < 20), ($urandom_range(99) < 70), ($urandom_range(99) < 20),
                    RAW'($urandom_range(NREGS - 1)), WIDTH'($urandom),
                    ($urandom_range(99) < 80), RAW'($urandom_range(NREGS - 1)), WIDTH'($urandom));
    end
    applyStimulus("idle", 1, 0, 0, 0, 0, 0, 16'h0, 0, 0, 16'hBEEF);

    waitCycles = 0;
    while (sbq.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    numChecks++;
    if (sbq.size() != 0) begin
      numFails++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
